// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and word-memory bus of the load/store unit
//
// Purpose: bundles the core-side request/response handshake and the word-memory
// strobes into one interface.
// Modports:
//   slave  - the load/store unit: takes req_*, mem_rdata; drives req_ready,
//            resp_*, mem_read, mem_write, mem_addr, mem_wdata.
//   master - the core plus memory side: the mirror image of slave.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte/halfword/word load-store unit over a word memory
//
// Purpose: accepts one load or store at a time, checks alignment and width code,
// performs loads with lane select and extension, and stores of byte/halfword
// width as read-modify-write of the containing word.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - load_store_unit_if.slave: request/response handshake and memory bus
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   load_store_unit_if.slave        bus
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;   // raw store data, then merged word
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  req_err;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_ext;
   logic [DATA_WIDTH-1:0] merged;

   // Legality of the request on the bus, evaluated in the accept cycle.
   always_comb begin
      req_err = 1'b0;
      if (bus.req_we) begin
         if (bus.req_funct3 > 3'd2) req_err = 1'b1;
      end else begin
         if (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7)
            req_err = 1'b1;
      end
      // funct3[1:0] = 01 covers H/HU/SH, 10 covers W/SW.
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
         req_err = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
         req_err = 1'b1;
   end

   // Load lane select and extension; funct3[2] set means zero-extend.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = bus.mem_rdata[7:0];
         2'd1:    ld_byte = bus.mem_rdata[15:8];
         2'd2:    ld_byte = bus.mem_rdata[23:16];
         default: ld_byte = bus.mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ld_ext = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
         2'b01:   ld_ext = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
         default: ld_ext = bus.mem_rdata;
      endcase
   end

   // Store merge: replace only the addressed lane(s) of the word just read.
   always_comb begin
      merged = bus.mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0]  = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d     = bus.req_we;
               funct3_d = bus.req_funct3;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               err_d    = req_err;
               if (req_err)                    state_d = RESP;
               else if (!bus.req_we)           state_d = LOAD;
               else if (bus.req_funct3 == 3'd2) state_d = WRITE;
               else                            state_d = RMW_RD;
            end
         end
         LOAD: begin
            rdata_d = ld_ext;
            state_d = RESP;
         end
         RMW_RD: begin
            wdata_d = merged;
            state_d = WRITE;
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // All outputs decode from registered state, so reset clears them at once.
   logic mem_phase;
   assign mem_phase      = (state_q == LOAD) || (state_q == RMW_RD) || (state_q == WRITE);
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.mem_read   = (state_q == LOAD) || (state_q == RMW_RD);
   assign bus.mem_write  = (state_q == WRITE);
   assign bus.mem_addr   = mem_phase ? {2'b00, addr_q[ADDR_WIDTH-1:2]} : '0;
   assign bus.mem_wdata  = (state_q == WRITE) ? wdata_q : '0;

   logic unused_ok;
   assign unused_ok = we_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  core presents a memory request.
REQ-006 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_WIDTH  extended load result.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal request, qualified by resp_valid.
REQ-014 SHALL have ports mem_read, mem_write  output  1 each  word-memory strobes.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  word index, {2'b00, addr[ADDR_WIDTH-1:2]}.
REQ-016 SHALL have ports mem_wdata  output  DATA_WIDTH, and mem_rdata  input  DATA_WIDTH (combinational memory read, registered write on rising clk).

Function
REQ-017 SHALL implement states IDLE, LOAD, RMW_RD, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 Accept = req_valid && req_ready at a rising edge; SHALL register we, funct3, addr, wdata at accept; request inputs are ignored outside IDLE.
REQ-019 Error check at accept: H/HU/store-H with addr[0]=1, W with addr[1:0]!=0, funct3 3/6/7 for loads, funct3 not 0/1/2 for stores -> IDLE to RESP with resp_err=1, no mem strobe ever asserted.
REQ-020 Legal load: IDLE->LOAD; LOAD drives mem_read=1, mem_addr=word index; at edge captures mem_rdata, selects byte addr[1:0] / halfword addr[1], sign-extends (B,H) or zero-extends (BU,HU) into resp_rdata; ->RESP.
REQ-021 Legal SW: IDLE->WRITE with merged word = req_wdata.
REQ-022 Legal SB/SH: IDLE->RMW_RD; RMW_RD drives mem_read=1, at edge merges wdata[7:0] (SB, lane addr[1:0]) or wdata[15:0] (SH, lane addr[1]) into mem_rdata, other lanes unchanged; ->WRITE.
REQ-023 WRITE SHALL drive mem_write=1, mem_wdata = merged word, mem_addr = word index for exactly one cycle; ->RESP.
REQ-024 RESP SHALL assert resp_valid for exactly one cycle then ->IDLE; no backpressure on responses.
REQ-025 Latency accept-cycle to resp_valid: error 1, load 2, SW 2, SB/SH 3 cycles; back-to-back request accepted in the cycle after RESP.
REQ-026 resp_rdata SHALL update only on load completion and hold otherwise; stores and errors leave it unchanged; resp_err cleared on every non-error response.
REQ-027 mem_read and mem_write SHALL never be asserted together; both 0 in IDLE and RESP; mem_wdata = 0 when mem_write = 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and clear captured request.
REQ-029 Reset asserted during RMW_RD or WRITE SHALL abort with no memory write issued after reset assertion; no response is generated for the aborted request.

Verification
REQ-030 Mem word 1 = 0x8899AABB; load LB addr 0x6 -> resp_rdata 0xFFFFFF99 two cycles after accept, resp_err 0; LBU same -> 0x00000099.
REQ-031 Mem word 1 = 0x11223344; SB addr 0x5, wdata 0xDEADBEEF -> one mem_write of 0x1122EF44 to index 1, resp_valid three cycles after accept.
REQ-032 SH addr 0x2 wdata 0x0000CAFE over word 0 = 0 -> write 0xCAFE0000; following LH addr 0x2 -> 0xFFFFCAFE.
REQ-033 LW addr 0x2 and SH addr 0x3 -> resp_err 1 one cycle after accept, mem_read/mem_write never asserted, memory unchanged.
REQ-034 SB in flight, rst_n low during RMW_RD -> all outputs at reset values, no mem_write, memory unchanged; next LW after release returns original word.
REQ-035 req_valid held high continuously for 4 SW requests -> accepts spaced 3 cycles apart, exactly one mem_write each, responses in order.
